mem_access_arbiter: RTL

//  Shares the single memory port (MFA/MFC handshake) between instruction fetch (port 0) and

---
 rtl/cpu_mem_pkg.sv | 12 +
 rtl/mem_access_arbiter_rr_arbiter2.sv | 10 +
 rtl/mem_access_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding and port/direction constants for the memory port arbiter
package cpu_mem_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;
    localparam logic RW_READ    = 1'b1;
    localparam logic WB_WORD    = 1'b1;
    localparam int   PORT_FETCH = 0;
    localparam int   PORT_DATA  = 1;
endpackage

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker; on a tie the port not granted last time wins
module rr_arbiter2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);
    assign pick = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the MFA/MFC memory port between fetch (port 0) and load/store (port 1)
module mem_access_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    req,
    input  logic [1:0]    rw,
    input  logic [1:0]    wb,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [1:0]    err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          MFA,
    output logic          READ_WRITE,
    output logic          WORD_BYTE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MFC
);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d, done_q, done_d, err_q, err_d, pick;
    logic [DW-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          mfa_q, mfa_d, rw_q, rw_d, wb_q, wb_d, last_q, last_d;

    rr_arbiter2 u_rr (.req(req), .last(last_q), .pick(pick));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mfa_d   = mfa_q;
        rw_d    = rw_q;
        wb_d    = wb_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (req != 2'b00) begin
                gnt_d   = pick;
                addr_d  = pick[1] ? addr1 : addr0;
                wdata_d = pick[1] ? wdata1 : wdata0;
                rw_d    = pick[1] ? rw[1] : rw[0];
                wb_d    = pick[1] ? wb[1] : wb[0];
                mfa_d   = 1'b1;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: if (MFC) begin
                done_d  = gnt_q;
                rdata_d = (rw_q == RW_READ) ? MEM_RDATA : rdata_q;
                mfa_d   = 1'b0;
                state_d = RELEASE;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                err_d   = gnt_q;
                mfa_d   = 1'b0;
                state_d = RELEASE;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
            // grant stays up until memory drops MFC, closing the 4-phase handshake
            RELEASE: if (!MFC) begin
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            mfa_q   <= 1'b0;
            rw_q    <= 1'b0;
            wb_q    <= 1'b0;
            last_q  <= 1'(PORT_DATA);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mfa_q   <= mfa_d;
            rw_q    <= rw_d;
            wb_q    <= wb_d;
            last_q  <= last_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign busy       = (state_q != IDLE);
    assign MFA        = mfa_q;
    assign READ_WRITE = rw_q;
    assign WORD_BYTE  = wb_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_WDATA  = wdata_q;
endmodule
